// File: rtl/xup_lib_defs_pkg.sv
// Shared definitions for the XUP serial-to-parallel word assembler.
// Word/counter widths, buffer state encodings and the bit-insertion helper.
package xup_lib_defs;

    localparam int WORD_W = 4;
    localparam int CNT_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // MSB-first pushes new bits in at bit 0 so the first bit ends up in the top bit;
    // LSB-first pushes in at the top so the first bit walks down to bit 0.
    function automatic logic [WORD_W-1:0] shift_in(
        input logic [WORD_W-1:0] cur,
        input logic              bit_in,
        input logic              msb_first
    );
        logic [WORD_W-1:0] nxt;
        if (msb_first) begin
            nxt = {cur[WORD_W-2:0], bit_in};
        end else begin
            nxt = {bit_in, cur[WORD_W-1:1]};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/xup_sipo_shift4.sv
// Four-bit serial shift stage with bit counter.
// Flags the edge that accepts the fourth bit and presents the finished word alongside it.
import xup_lib_defs::*;

module xup_sipo_shift4 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [WORD_W-1:0] word_done,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;
    logic [WORD_W-1:0] shift_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        shift_next = shift_in(shift_q, sin, MSB_FIRST);
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        // clear outranks a simultaneous sample: the bit is discarded
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (sin_valid) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + CNT_W'(1);
            done    = (cnt_q == LAST_BIT);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_done = shift_next;
    assign bit_count = cnt_q;

endmodule

// File: rtl/xup_sipo4_rx.sv
// Serial-to-parallel nibble receiver with a one-word valid/ready output buffer,
// sticky overrun on dropped words and an all-ones flag on the presented word.
//
//   state | meaning
//   EMPTY | no unconsumed word; out_valid=0
//   FULL  | word holds an unconsumed word; out_valid=1
import xup_lib_defs::*;

module xup_sipo4_rx #(
    parameter int DELAY     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [WORD_W-1:0] word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              all_ones,
    output logic              overrun,
    output logic [CNT_W-1:0]  bit_count
);

    // DELAY only described gate propagation in the behavioural library model;
    // registered outputs here switch directly on the clock edge.
    if (DELAY < 0) begin : g_delay_range
    end

    buf_state_t        state_q;
    buf_state_t        state_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic              overrun_q;
    logic              overrun_d;
    logic [WORD_W-1:0] word_done;
    logic              done;

    xup_sipo_shift4 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .sin       (sin),
        .sin_valid (sin_valid),
        .word_done (word_done),
        .done      (done),
        .bit_count (bit_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= EMPTY;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        overrun_d = overrun_q;
        unique case (state_q)
            EMPTY: begin
                if (done) begin
                    state_d = FULL;
                    word_d  = word_done;
                end
            end
            FULL: begin
                if (out_ready) begin
                    // consume and reload on the same edge keeps valid high with no bubble
                    if (done) begin
                        word_d = word_done;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (done) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign word      = word_q;
    assign out_valid = (state_q == FULL);
    assign all_ones  = out_valid && (word_q == {WORD_W{1'b1}});
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_xup_sipo4_rx.sv
// Self-checking bench for xup_sipo4_rx: an MSB-first and an LSB-first instance share
// the same stimulus and are compared against a bit-list reference model every cycle.
module tb_xup_sipo4_rx;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clear = 1'b0;
    logic sin = 1'b0;
    logic sin_valid = 1'b0;
    logic out_ready = 1'b0;

    logic [3:0] word_m, word_l;
    logic       out_valid_m, out_valid_l;
    logic       all_ones_m, all_ones_l;
    logic       overrun_m, overrun_l;
    logic [1:0] bit_count_m, bit_count_l;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   m_cnt;
    int   m_bits [4];
    logic m_valid;
    int   m_word_m;
    int   m_word_l;
    logic m_ovr;

    always #5 clk = ~clk;

    xup_sipo4_rx #(.DELAY(3), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .resetn(resetn), .clear(clear), .sin(sin), .sin_valid(sin_valid),
        .word(word_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .all_ones(all_ones_m), .overrun(overrun_m), .bit_count(bit_count_m)
    );

    xup_sipo4_rx #(.DELAY(3), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .resetn(resetn), .clear(clear), .sin(sin), .sin_valid(sin_valid),
        .word(word_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .all_ones(all_ones_l), .overrun(overrun_l), .bit_count(bit_count_l)
    );

    function automatic logic [8:0] exp_vec(input bit msb);
        logic [3:0] w;
        w = msb ? 4'(m_word_m) : 4'(m_word_l);
        return {w, m_valid, m_valid && (w == 4'hF), m_ovr, 2'(m_cnt)};
    endfunction

    function automatic logic [8:0] act_m();
        return {word_m, out_valid_m, all_ones_m, overrun_m, bit_count_m};
    endfunction

    function automatic logic [8:0] act_l();
        return {word_l, out_valid_l, all_ones_l, overrun_l, bit_count_l};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_valid = 1'b0;
        m_word_m = 0;
        m_word_l = 0;
        m_ovr = 1'b0;
        for (int i = 0; i < 4; i++) m_bits[i] = 0;
    endtask

    task automatic model_edge(input logic b, input logic v, input logic c, input logic r);
        bit done;
        int wm, wl;
        done = 0;
        wm = 0;
        wl = 0;
        if (c) begin
            m_cnt = 0;
        end else if (v) begin
            m_bits[m_cnt] = int'(b);
            m_cnt++;
            if (m_cnt == 4) begin
                done = 1;
                wm = m_bits[0] * 8 + m_bits[1] * 4 + m_bits[2] * 2 + m_bits[3];
                wl = m_bits[0] + m_bits[1] * 2 + m_bits[2] * 4 + m_bits[3] * 8;
                m_cnt = 0;
            end
        end
        if (!m_valid) begin
            if (done) begin
                m_valid = 1'b1;
                m_word_m = wm;
                m_word_l = wl;
            end
        end else if (r) begin
            if (done) begin
                m_word_m = wm;
                m_word_l = wl;
            end else begin
                m_valid = 1'b0;
            end
        end else if (done) begin
            m_ovr = 1'b1;
        end
    endtask

    // drive one clock of inputs, advance the model at the edge, return at the next falling edge
    task automatic step(input logic b, input logic v, input logic c, input logic r);
        sin = b;
        sin_valid = v;
        clear = c;
        out_ready = r;
        @(posedge clk);
        model_edge(b, v, c, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        sin = 1'b0;
        sin_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act_m() !== 9'd0 || act_l() !== 9'd0) begin
            errors++;
            $display("FAIL reset_state: got m=%b l=%b want 000000000", act_m(), act_l());
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] bits;
        do_reset();
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            checks++;
            if (act_m() !== exp_vec(1) || act_l() !== exp_vec(0)) begin
                errors++;
                $display("FAIL msb_first_cycle%0d: got m=%b l=%b want m=%b l=%b",
                         3 - i, act_m(), act_l(), exp_vec(1), exp_vec(0));
            end
        end
        checks++;
        if (word_m !== 4'b1011 || out_valid_m !== 1'b1 || all_ones_m !== 1'b0 || overrun_m !== 1'b0) begin
            errors++;
            $display("FAIL msb_first_word: got word=%b v=%b ao=%b ov=%b want 1011 1 0 0",
                     word_m, out_valid_m, all_ones_m, overrun_m);
        end
    endtask

    task automatic test_all_ones_lsb();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (word_l !== 4'b1111 || all_ones_l !== 1'b1 || out_valid_l !== 1'b1) begin
            errors++;
            $display("FAIL all_ones_set: got word=%b ao=%b v=%b want 1111 1 1", word_l, all_ones_l, out_valid_l);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid_l !== 1'b0 || all_ones_l !== 1'b0 || word_l !== 4'b1111) begin
            errors++;
            $display("FAIL all_ones_consume: got v=%b ao=%b word=%b want 0 0 1111", out_valid_l, all_ones_l, word_l);
        end
        checks++;
        if (act_m() !== exp_vec(1) || act_l() !== exp_vec(0)) begin
            errors++;
            $display("FAIL all_ones_model: got m=%b l=%b want m=%b l=%b", act_m(), act_l(), exp_vec(1), exp_vec(0));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        do_reset();
        bits = 8'b0011_0101;
        for (int i = 7; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, 1'b1);
            checks++;
            if (act_m() !== exp_vec(1) || act_l() !== exp_vec(0)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got m=%b l=%b want m=%b l=%b",
                         7 - i, act_m(), act_l(), exp_vec(1), exp_vec(0));
            end
            if (i == 4) begin
                checks++;
                if (out_valid_m !== 1'b1 || word_m !== 4'b0011) begin
                    errors++;
                    $display("FAIL b2b_word1: got v=%b word=%b want 1 0011", out_valid_m, word_m);
                end
            end
        end
        checks++;
        if (out_valid_m !== 1'b1 || word_m !== 4'b0101) begin
            errors++;
            $display("FAIL b2b_word2: got v=%b word=%b want 1 0101", out_valid_m, word_m);
        end
        // a consume coinciding with a completion must reload without dropping valid
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid_m !== 1'b1 || word_m !== 4'b1110 || overrun_m !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: got v=%b word=%b ov=%b want 1 1110 0", out_valid_m, word_m, overrun_m);
        end
    endtask

    task automatic test_overrun();
        logic [3:0] first_m;
        logic b;
        do_reset();
        first_m = '0;
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom_range(0, 1));
            if (i < 4) first_m[3 - i] = b;
            step(b, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (overrun_m !== 1'b1 || overrun_l !== 1'b1 || word_m !== first_m || out_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got ov=%b/%b word=%b v=%b want 1/1 %b 1",
                     overrun_m, overrun_l, word_m, out_valid_m, first_m);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end
        checks++;
        if (overrun_m !== 1'b1 || overrun_l !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b/%b want 1/1", overrun_m, overrun_l);
        end
        do_reset();
        checks++;
        if (overrun_m !== 1'b0 || overrun_l !== 1'b0) begin
            errors++;
            $display("FAIL overrun_reset: got %b/%b want 0/0", overrun_m, overrun_l);
        end
    endtask

    task automatic test_clear();
        logic [3:0] bits;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bit_count_m !== 2'd0 || bit_count_l !== 2'd0 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL clear_count: got cnt=%0d/%0d v=%b want 0/0 0", bit_count_m, bit_count_l, out_valid_m);
        end
        bits = 4'b1001;
        for (int i = 3; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
        checks++;
        if (word_m !== 4'b1001 || word_l !== 4'b1001 || out_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL clear_word: got m=%b l=%b v=%b want 1001 1001 1", word_m, word_l, out_valid_m);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] bits;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid_m !== 1'b1 || bit_count_m !== 2'd2 || all_ones_m !== 1'b1) begin
            errors++;
            $display("FAIL async_setup: got v=%b cnt=%0d ao=%b want 1 2 1", out_valid_m, bit_count_m, all_ones_m);
        end
        sin_valid = 1'b0;
        #1;
        resetn = 1'b0;
        model_reset();
        #3;
        checks++;
        if (act_m() !== 9'd0 || act_l() !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got m=%b l=%b want 000000000", act_m(), act_l());
        end
        @(negedge clk);
        resetn = 1'b1;
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
        checks++;
        if (word_m !== 4'b0110 || word_l !== 4'b0110 || out_valid_m !== 1'b1 || overrun_m !== 1'b0) begin
            errors++;
            $display("FAIL async_clean_word: got m=%b l=%b v=%b ov=%b want 0110 0110 1 0",
                     word_m, word_l, out_valid_m, overrun_m);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (act_m() !== exp_vec(1) || act_l() !== exp_vec(0)) begin
                errors++;
                $display("FAIL random_cycle%0d: got m=%b l=%b want m=%b l=%b",
                         i, act_m(), act_l(), exp_vec(1), exp_vec(0));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_msb_first();
        test_all_ones_lsb();
        test_back_to_back();
        test_overrun();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
